// File: rtl/modn_timer_arbiter_if.sv
// modn_timer_arbiter_if: request/terminal-value bus between timed clients and the shared counter
interface modn_timer_arbiter_if #(
    parameter int NREQ = 4,
    parameter int W    = 8
);
    logic              en;
    logic [NREQ-1:0]   req;
    logic [NREQ*W-1:0] len;
    logic [NREQ-1:0]   grant;
    logic [W-1:0]      count;
    logic [NREQ-1:0]   done;
    logic              busy;
    modport master (output en, req, len, input grant, count, done, busy);
    modport slave  (input en, req, len, output grant, count, done, busy);
endinterface

// File: rtl/modn_timer_arbiter.sv
// modn_timer_arbiter: round-robin owner of one terminal counter, one-cycle done pulse per finished job
module modn_timer_arbiter #(
    parameter int NREQ = 4,
    parameter int W    = 8
) (
    input logic                 clk,
    input logic                 reset,
    modn_timer_arbiter_if.slave bus
);
    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t        state_q, state_d;
    logic [PW-1:0] ptr_q, ptr_d, owner_q, owner_d, pick, owner_nxt;
    logic [W-1:0]  term_q, term_d, count_q, count_d;
    // Scan downwards so the requester closest to ptr_q is the last (winning) assignment.
    always_comb begin
        pick = ptr_q;
        for (int k = NREQ - 1; k >= 0; k--)
            if (bus.req[(int'(ptr_q) + k) % NREQ]) pick = PW'((int'(ptr_q) + k) % NREQ);
    end
    assign owner_nxt = PW'((int'(owner_q) + 1) % NREQ);
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        owner_d = owner_q;
        term_d  = term_q;
        count_d = count_q;
        case (state_q)
            IDLE: if (|bus.req) begin
                state_d = RUN;
                owner_d = pick;
                term_d  = bus.len[pick*W +: W];
                count_d = '0;
            end
            RUN: if (!bus.req[owner_q]) begin
                state_d = IDLE;
                count_d = '0;
                ptr_d   = owner_nxt;
            end else if (bus.en) begin
                state_d = (count_q == term_q) ? DONE : RUN;
                count_d = (count_q == term_q) ? '0 : count_q + W'(1);
            end
            DONE: begin
                state_d = IDLE;
                ptr_d   = owner_nxt;
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            owner_q <= '0;
            term_q  <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            owner_q <= owner_d;
            term_q  <= term_d;
            count_q <= count_d;
        end
    end
    assign bus.grant = (state_q != IDLE) ? NREQ'(1) << owner_q : '0;
    assign bus.done  = (state_q == DONE) ? NREQ'(1) << owner_q : '0;
    assign bus.count = count_q;
    assign bus.busy  = state_q != IDLE;
endmodule
